// File: rtl/fu_scoreboard_ctrl_if.sv
// rtl/fu_scoreboard_ctrl_if.sv - ID issue, FU handshake and write-back signals of the scoreboard controller
interface fu_scoreboard_ctrl_if;
  logic       id_valid;
  logic [2:0] id_fu;
  logic [4:0] id_rd;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       id_we;
  logic       id_ready;
  logic [4:0] fu_en;
  logic [4:0] fu_finish;
  logic [4:0] fu_busy;
  logic       wb_valid;
  logic       wb_we;
  logic [4:0] wb_rd;
  logic [2:0] wb_sel;

  modport master (
    output id_valid, id_fu, id_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_we, fu_finish,
    input  id_ready, fu_en, fu_busy, wb_valid, wb_we, wb_rd, wb_sel
  );

  modport slave (
    input  id_valid, id_fu, id_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_we, fu_finish,
    output id_ready, fu_en, fu_busy, wb_valid, wb_we, wb_rd, wb_sel
  );
endinterface

// File: rtl/fu_scoreboard_ctrl.sv
// rtl/fu_scoreboard_ctrl.sv - scoreboard issue and single-port write-back arbiter for five FUs
module fu_scoreboard_ctrl (
  input  logic                clk,
  input  logic                rst,
  fu_scoreboard_ctrl_if.slave bus
);
  localparam int         NUM_FU   = 5;
  localparam int         NUM_REGS = 32;
  localparam logic [2:0] FU_JUMP  = 3'd4;

  logic [NUM_FU-1:0]   busy;
  logic [NUM_FU-1:0]   done;
  logic [NUM_FU-1:0]   fu_we;
  logic [4:0]          fu_rd [NUM_FU];
  logic [NUM_REGS-1:0] st_valid;
  logic [2:0]          st_fu [NUM_REGS];

  logic       fu_legal;
  logic       raw1;
  logic       raw2;
  logic       waw;
  logic       issue;
  logic [7:0] busy_ext;
  logic       win_found;
  logic [2:0] win_idx;
  logic [4:0] win_rd;

  // Illegal FU codes 5..7 read as permanently busy, so they never issue.
  always_comb begin
    busy_ext = {3'b111, busy};
    fu_legal = (bus.id_fu < 3'd5);
    raw1     = bus.id_use_rs1 && (bus.id_rs1 != 5'd0) && st_valid[bus.id_rs1];
    raw2     = bus.id_use_rs2 && (bus.id_rs2 != 5'd0) && st_valid[bus.id_rs2];
    waw      = bus.id_we && (bus.id_rd != 5'd0) && st_valid[bus.id_rd];
    issue    = bus.id_valid && fu_legal && !busy_ext[bus.id_fu] && !busy[FU_JUMP]
               && !raw1 && !raw2 && !waw;
  end

  // Descending scan so the lowest-index done FU is the last assignment and wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (done[i]) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
      end
    end
    win_rd = fu_rd[win_idx];
  end

  assign bus.id_ready = issue;
  assign bus.fu_en    = issue ? (5'b00001 << bus.id_fu) : 5'b00000;
  assign bus.fu_busy  = busy;
  assign bus.wb_valid = win_found;
  assign bus.wb_sel   = win_found ? (win_idx + 3'd1) : 3'd0;
  assign bus.wb_rd    = win_found ? win_rd : 5'd0;
  assign bus.wb_we    = win_found && fu_we[win_idx] && (win_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy     <= '0;
      done     <= '0;
      fu_we    <= '0;
      st_valid <= '0;
      for (int i = 0; i < NUM_FU; i++) fu_rd[i] <= 5'd0;
      for (int r = 0; r < NUM_REGS; r++) st_fu[r] <= 3'd0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (bus.fu_finish[i] && busy[i] && !done[i]) done[i] <= 1'b1;
      end

      // A retiring FU only releases the status entry it still owns.
      if (win_found) begin
        done[win_idx] <= 1'b0;
        busy[win_idx] <= 1'b0;
        if (fu_we[win_idx] && st_fu[win_rd] == win_idx) st_valid[win_rd] <= 1'b0;
      end

      if (issue) begin
        busy[bus.id_fu]  <= 1'b1;
        fu_rd[bus.id_fu] <= bus.id_rd;
        fu_we[bus.id_fu] <= bus.id_we;
        if (bus.id_we && bus.id_rd != 5'd0) begin
          st_valid[bus.id_rd] <= 1'b1;
          st_fu[bus.id_rd]    <= bus.id_fu;
        end
      end
    end
  end
endmodule

// File: tb/tb_fu_scoreboard_ctrl.sv
// tb/tb_fu_scoreboard_ctrl.sv - directed self-checking bench for fu_scoreboard_ctrl
module tb_fu_scoreboard_ctrl;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  fu_scoreboard_ctrl_if bus ();

  fu_scoreboard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [2:0] fu, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic we);
    bus.id_valid   = v;
    bus.id_fu      = fu;
    bus.id_rd      = rd;
    bus.id_rs1     = rs1;
    bus.id_rs2     = rs2;
    bus.id_use_rs1 = u1;
    bus.id_use_rs2 = u2;
    bus.id_we      = we;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_id(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.fu_finish = 5'b00000;
    cyc();
    cyc();
    @(negedge clk);
    n_chk++; if (bus.id_ready !== 1'b0) $display("FAIL rst_id_ready got %b exp 0", bus.id_ready); else n_pass++;
    n_chk++; if (bus.fu_en !== 5'b00000) $display("FAIL rst_fu_en got %b exp 00000", bus.fu_en); else n_pass++;
    n_chk++; if (bus.fu_busy !== 5'b00000) $display("FAIL rst_fu_busy got %b exp 00000", bus.fu_busy); else n_pass++;
    n_chk++; if ({bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_sel} !== 10'd0)
      $display("FAIL rst_wb got v=%b we=%b rd=%0d sel=%0d exp all 0", bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_sel);
    else n_pass++;
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_alu_basic();
    set_id(1'b1, 3'd0, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    n_chk++; if (bus.id_ready !== 1'b1) $display("FAIL alu_id_ready got %b exp 1", bus.id_ready); else n_pass++;
    n_chk++; if (bus.fu_en !== 5'b00001) $display("FAIL alu_fu_en got %b exp 00001", bus.fu_en); else n_pass++;
    cyc();
    set_id(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.fu_finish = 5'b00001;
    @(negedge clk);
    n_chk++; if (bus.fu_busy !== 5'b00001) $display("FAIL alu_busy got %b exp 00001", bus.fu_busy); else n_pass++;
    n_chk++; if (bus.wb_valid !== 1'b0) $display("FAIL alu_wb_early got %b exp 0", bus.wb_valid); else n_pass++;
    cyc();
    bus.fu_finish = 5'b00000;
    @(negedge clk);
    n_chk++; if ({bus.wb_valid, bus.wb_sel, bus.wb_rd, bus.wb_we} !== {1'b1, 3'd1, 5'd5, 1'b1})
      $display("FAIL alu_wb got v=%b sel=%0d rd=%0d we=%b exp v=1 sel=1 rd=5 we=1", bus.wb_valid, bus.wb_sel, bus.wb_rd, bus.wb_we);
    else n_pass++;
    cyc();
    @(negedge clk);
    n_chk++; if (bus.fu_busy !== 5'b00000) $display("FAIL alu_busy_clear got %b exp 00000", bus.fu_busy); else n_pass++;
    n_chk++; if (bus.wb_valid !== 1'b0) $display("FAIL alu_wb_after got %b exp 0", bus.wb_valid); else n_pass++;
    cyc();
  endtask

  task automatic test_raw_div_alu();
    set_id(1'b1, 3'd3, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    n_chk++; if (bus.fu_en !== 5'b01000) $display("FAIL raw_div_en got %b exp 01000", bus.fu_en); else n_pass++;
    cyc();
    set_id(1'b1, 3'd0, 5'd7, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    n_chk++; if (bus.id_ready !== 1'b0) $display("FAIL raw_stall1 got %b exp 0", bus.id_ready); else n_pass++;
    cyc();
    bus.fu_finish = 5'b01000;
    @(negedge clk);
    n_chk++; if (bus.id_ready !== 1'b0) $display("FAIL raw_stall2 got %b exp 0", bus.id_ready); else n_pass++;
    cyc();
    bus.fu_finish = 5'b00000;
    @(negedge clk);
    n_chk++; if ({bus.wb_sel, bus.wb_rd} !== {3'd4, 5'd3})
      $display("FAIL raw_div_wb got sel=%0d rd=%0d exp sel=4 rd=3", bus.wb_sel, bus.wb_rd);
    else n_pass++;
    n_chk++; if (bus.id_ready !== 1'b0) $display("FAIL raw_no_bypass got %b exp 0", bus.id_ready); else n_pass++;
    cyc();
    @(negedge clk);
    n_chk++; if (bus.fu_en !== 5'b00001) $display("FAIL raw_alu_issue got %b exp 00001", bus.fu_en); else n_pass++;
    cyc();
    set_id(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.fu_finish = 5'b00001;
    cyc();
    bus.fu_finish = 5'b00000;
    @(negedge clk);
    n_chk++; if ({bus.wb_sel, bus.wb_rd} !== {3'd1, 5'd7})
      $display("FAIL raw_alu_wb got sel=%0d rd=%0d exp sel=1 rd=7", bus.wb_sel, bus.wb_rd);
    else n_pass++;
    cyc();
  endtask

  task automatic test_back_to_back();
    set_id(1'b1, 3'd2, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc();
    set_id(1'b1, 3'd0, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_chk++; if (bus.fu_en !== 5'b00001) $display("FAIL b2b_alu_en got %b exp 00001", bus.fu_en); else n_pass++;
    cyc();
    set_id(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.fu_finish = 5'b00101;
    cyc();
    bus.fu_finish = 5'b00000;
    @(negedge clk);
    n_chk++; if ({bus.wb_valid, bus.wb_sel, bus.wb_rd} !== {1'b1, 3'd1, 5'd6})
      $display("FAIL b2b_first got v=%b sel=%0d rd=%0d exp v=1 sel=1 rd=6", bus.wb_valid, bus.wb_sel, bus.wb_rd);
    else n_pass++;
    cyc();
    @(negedge clk);
    n_chk++; if ({bus.wb_valid, bus.wb_sel, bus.wb_rd, bus.wb_we} !== {1'b1, 3'd3, 5'd4, 1'b1})
      $display("FAIL b2b_second got v=%b sel=%0d rd=%0d we=%b exp v=1 sel=3 rd=4 we=1", bus.wb_valid, bus.wb_sel, bus.wb_rd, bus.wb_we);
    else n_pass++;
    cyc();
    @(negedge clk);
    n_chk++; if ({bus.wb_valid, bus.fu_busy} !== 6'd0)
      $display("FAIL b2b_drain got v=%b busy=%b exp v=0 busy=00000", bus.wb_valid, bus.fu_busy);
    else n_pass++;
    cyc();
  endtask

  task automatic test_jump_stall();
    set_id(1'b1, 3'd4, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    n_chk++; if (bus.fu_en !== 5'b10000) $display("FAIL jmp_en got %b exp 10000", bus.fu_en); else n_pass++;
    cyc();
    set_id(1'b1, 3'd0, 5'd8, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    n_chk++; if ({bus.id_ready, bus.fu_busy} !== {1'b0, 5'b10000})
      $display("FAIL jmp_stall got rdy=%b busy=%b exp rdy=0 busy=10000", bus.id_ready, bus.fu_busy);
    else n_pass++;
    cyc();
    bus.fu_finish = 5'b10000;
    cyc();
    bus.fu_finish = 5'b00000;
    @(negedge clk);
    n_chk++; if ({bus.wb_sel, bus.wb_rd, bus.wb_we, bus.id_ready} !== {3'd5, 5'd1, 1'b1, 1'b0})
      $display("FAIL jmp_wb got sel=%0d rd=%0d we=%b rdy=%b exp sel=5 rd=1 we=1 rdy=0", bus.wb_sel, bus.wb_rd, bus.wb_we, bus.id_ready);
    else n_pass++;
    cyc();
    @(negedge clk);
    n_chk++; if (bus.id_ready !== 1'b1) $display("FAIL jmp_release got %b exp 1", bus.id_ready); else n_pass++;
    cyc();
    set_id(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.fu_finish = 5'b00001;
    cyc();
    bus.fu_finish = 5'b00000;
    cyc();
  endtask

  task automatic test_store_mem();
    set_id(1'b1, 3'd1, 5'd0, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
    cyc();
    set_id(1'b1, 3'd1, 5'd10, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    n_chk++; if (bus.id_ready !== 1'b0) $display("FAIL st_busy_stall got %b exp 0", bus.id_ready); else n_pass++;
    cyc();
    bus.fu_finish = 5'b00010;
    cyc();
    bus.fu_finish = 5'b00000;
    @(negedge clk);
    n_chk++; if ({bus.wb_valid, bus.wb_we, bus.wb_sel, bus.id_ready} !== {1'b1, 1'b0, 3'd2, 1'b0})
      $display("FAIL st_wb got v=%b we=%b sel=%0d rdy=%b exp v=1 we=0 sel=2 rdy=0", bus.wb_valid, bus.wb_we, bus.wb_sel, bus.id_ready);
    else n_pass++;
    cyc();
    @(negedge clk);
    n_chk++; if (bus.fu_en !== 5'b00010) $display("FAIL st_load_issue got %b exp 00010", bus.fu_en); else n_pass++;
    cyc();
    set_id(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.fu_finish = 5'b00010;
    cyc();
    bus.fu_finish = 5'b00000;
    @(negedge clk);
    n_chk++; if ({bus.wb_we, bus.wb_rd} !== {1'b1, 5'd10})
      $display("FAIL st_load_wb got we=%b rd=%0d exp we=1 rd=10", bus.wb_we, bus.wb_rd);
    else n_pass++;
    cyc();
  endtask

  task automatic test_boundary();
    set_id(1'b1, 3'd6, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_chk++; if ({bus.id_ready, bus.fu_en} !== 6'd0)
      $display("FAIL bnd_illegal_fu got rdy=%b en=%b exp 0/00000", bus.id_ready, bus.fu_en);
    else n_pass++;
    cyc();
    set_id(1'b1, 3'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    n_chk++; if (bus.id_ready !== 1'b1) $display("FAIL bnd_x0_issue got %b exp 1", bus.id_ready); else n_pass++;
    cyc();
    set_id(1'b1, 3'd2, 5'd13, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    bus.fu_finish = 5'b00001;
    @(negedge clk);
    n_chk++; if (bus.fu_en !== 5'b00100) $display("FAIL bnd_x0_src got %b exp 00100", bus.fu_en); else n_pass++;
    cyc();
    set_id(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.fu_finish = 5'b00000;
    @(negedge clk);
    n_chk++; if ({bus.wb_valid, bus.wb_we, bus.wb_sel} !== {1'b1, 1'b0, 3'd1})
      $display("FAIL bnd_x0_wb got v=%b we=%b sel=%0d exp v=1 we=0 sel=1", bus.wb_valid, bus.wb_we, bus.wb_sel);
    else n_pass++;
    cyc();
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    n_chk++; if (bus.fu_busy !== 5'b00100) $display("FAIL rmo_pre_busy got %b exp 00100", bus.fu_busy); else n_pass++;
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    bus.fu_finish = 5'b00100;
    @(negedge clk);
    n_chk++; if ({bus.fu_busy, bus.wb_valid, bus.wb_sel, bus.wb_rd, bus.id_ready} !== 15'd0)
      $display("FAIL rmo_cleared got busy=%b v=%b sel=%0d rd=%0d rdy=%b exp all 0", bus.fu_busy, bus.wb_valid, bus.wb_sel, bus.wb_rd, bus.id_ready);
    else n_pass++;
    cyc();
    bus.fu_finish = 5'b00000;
    set_id(1'b1, 3'd2, 5'd13, 5'd13, 5'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    n_chk++; if ({bus.wb_valid, bus.fu_en} !== {1'b0, 5'b00100})
      $display("FAIL rmo_reissue got v=%b en=%b exp v=0 en=00100", bus.wb_valid, bus.fu_en);
    else n_pass++;
    cyc();
    set_id(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_alu_basic();
    test_raw_div_alu();
    test_back_to_back();
    test_jump_stall();
    test_store_mem();
    test_boundary();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
